dbg_apb_fabric: RTL and testbench

DBG_APB_FABRIC -- requirements
Module: dbg_apb_fabric

---
 rtl/dbg_apb_fabric.sv | 172 +++++++++++++++++
 tb/tb_dbg_apb_fabric.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_apb_fabric.sv
// Debug-master to APB bridge: one outstanding transfer, address-decoded
// slave select, bounded ACCESS wait and a registered response channel.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// SETUP  | psel asserted, penable low (first APB phase)
// ACCESS | penable high, waiting for pready of the selected slave
// RESP   | rsp_valid high until the master takes the response
module dbg_apb_fabric #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NR_SLAVES   = 4,
  parameter int REGION_BITS = 12,
  parameter int TIMEOUT     = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_write,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [NR_SLAVES-1:0]    psel,
  output logic                    penable,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [NR_SLAVES-1:0]    pready,
  input  logic [NR_SLAVES-1:0]    pslverr,
  input  logic [DATA_WIDTH-1:0]   prdata [NR_SLAVES]
);

  localparam int SW = (NR_SLAVES > 1) ? $clog2(NR_SLAVES) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t                  state_q, state_nxt;
  logic [SW-1:0]           sel_idx_q, sel_idx_nxt;
  logic [CW-1:0]           wait_q, wait_nxt;
  logic [NR_SLAVES-1:0]    psel_nxt;
  logic                    penable_nxt, pwrite_nxt, rsp_valid_nxt, rsp_err_nxt;
  logic [ADDR_WIDTH-1:0]   paddr_nxt;
  logic [DATA_WIDTH-1:0]   pwdata_nxt, rsp_rdata_nxt;
  logic [DATA_WIDTH/8-1:0] pstrb_nxt;

  logic [ADDR_WIDTH-1:0]   region;
  logic                    hit;
  logic                    sel_ready;
  logic                    timeout_hit;

  assign region      = req_addr >> REGION_BITS;
  assign hit         = region < ADDR_WIDTH'(NR_SLAVES);
  assign sel_ready   = pready[sel_idx_q];
  assign timeout_hit = (TIMEOUT != 0) && (wait_q == CW'(TIMEOUT));
  assign req_ready   = (state_q == ST_IDLE);

  // State and registered outputs; reset discards any in-flight transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sel_idx_q <= '0;
      wait_q    <= '0;
      psel      <= '0;
      penable   <= 1'b0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      pstrb     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      sel_idx_q <= sel_idx_nxt;
      wait_q    <= wait_nxt;
      psel      <= psel_nxt;
      penable   <= penable_nxt;
      paddr     <= paddr_nxt;
      pwrite    <= pwrite_nxt;
      pwdata    <= pwdata_nxt;
      pstrb     <= pstrb_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      rsp_err   <= rsp_err_nxt;
    end
  end

  // Next-state: completion has priority over the timeout abort
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:   if (req_valid) state_nxt = hit ? ST_SETUP : ST_RESP;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: if (sel_ready || timeout_hit) state_nxt = ST_RESP;
      ST_RESP:   if (rsp_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; defaults drop psel/penable/rsp_valid
  always_comb begin
    sel_idx_nxt   = sel_idx_q;
    wait_nxt      = wait_q;
    psel_nxt      = '0;
    penable_nxt   = 1'b0;
    paddr_nxt     = paddr;
    pwrite_nxt    = pwrite;
    pwdata_nxt    = pwdata;
    pstrb_nxt     = pstrb;
    rsp_valid_nxt = 1'b0;
    rsp_rdata_nxt = rsp_rdata;
    rsp_err_nxt   = rsp_err;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (hit) begin
            sel_idx_nxt = SW'(region);
            psel_nxt    = NR_SLAVES'(1) << SW'(region);
            paddr_nxt   = req_addr;
            pwrite_nxt  = req_write;
            pwdata_nxt  = req_wdata;
            pstrb_nxt   = req_strb;
          end else begin
            rsp_valid_nxt = 1'b1;
            rsp_rdata_nxt = '0;
            rsp_err_nxt   = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        psel_nxt    = psel;
        penable_nxt = 1'b1;
        wait_nxt    = '0;
      end
      ST_ACCESS: begin
        if (sel_ready) begin
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = pwrite ? '0 : prdata[sel_idx_q];
          rsp_err_nxt   = pslverr[sel_idx_q];
        end else if (timeout_hit) begin
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = '0;
          rsp_err_nxt   = 1'b1;
        end else begin
          psel_nxt    = psel;
          penable_nxt = 1'b1;
          wait_nxt    = (wait_q == CW'(TIMEOUT)) ? wait_q : wait_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (!rsp_ready) rsp_valid_nxt = 1'b1;
      end
      default: begin
        sel_idx_nxt = '0;
        wait_nxt    = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_dbg_apb_fabric.sv
// Bench for dbg_apb_fabric: directed vector table, reset-during-ACCESS
// sequence and randomized transfers against a transaction-level model.
module tb_dbg_apb_fabric;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam int RB = 12;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [AW-1:0]   req_addr = '0;
  logic            req_write = 1'b0;
  logic [DW-1:0]   req_wdata = '0;
  logic [DW/8-1:0] req_strb = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic [NS-1:0]   psel;
  logic            penable;
  logic [AW-1:0]   paddr;
  logic            pwrite;
  logic [DW-1:0]   pwdata;
  logic [DW/8-1:0] pstrb;
  logic [NS-1:0]   pready = '0;
  logic [NS-1:0]   pslverr = '0;
  logic [DW-1:0]   prdata [NS];

  int          slv_wait [NS];
  logic [31:0] slv_data [NS];
  logic        slv_err  [NS];
  int          acnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          swait;
    logic [31:0] sdata;
    logic        serr;
    int          hold;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t tbl [10];

  dbg_apb_fabric #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_SLAVES(NS), .REGION_BITS(RB), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  always #5 clk = ~clk;

  // Slave models: the selected slave answers after slv_wait ACCESS cycles;
  // every other input carries random noise that the bridge must ignore.
  always @(negedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (psel[i] && penable) begin
        pready[i]  = (acnt >= slv_wait[i]);
        prdata[i]  = slv_data[i];
        pslverr[i] = slv_err[i];
      end else begin
        pready[i]  = 1'($urandom);
        prdata[i]  = $urandom;
        pslverr[i] = 1'($urandom);
      end
    end
    if ((|psel) && penable) acnt = acnt + 1;
    else acnt = 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Expected outcome of one transfer from the bridge's documented rules
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int   idx = int'(v.addr >> RB);
    if (idx >= NS) begin
      r.exp_err = 1'b1; r.exp_rdata = '0; r.exp_lat = 1;
    end else if (v.swait > TO) begin
      r.exp_err = 1'b1; r.exp_rdata = '0; r.exp_lat = TO + 3;
    end else begin
      r.exp_err = v.serr; r.exp_rdata = v.wr ? 32'h0 : v.sdata; r.exp_lat = v.swait + 3;
    end
    return r;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int          idx;
    logic [3:0]  exp_psel;
    int          lat;
    int          bad;
    int          hbad;
    logic [31:0] r0;
    logic        e0;
    idx = int'(v.addr >> RB);
    if (idx < NS) begin
      slv_wait[idx] = v.swait;
      slv_data[idx] = v.sdata;
      slv_err[idx]  = v.serr;
      exp_psel      = 4'(1 << idx);
    end else begin
      exp_psel = 4'h0;
    end
    @(negedge clk);
    req_valid = 1'b1; req_addr = v.addr; req_write = v.wr;
    req_wdata = v.wdata; req_strb = v.strb;
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_strb = 4'($urandom);
    lat = 0; bad = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = k; break; end
      if (psel !== exp_psel || penable !== ((idx < NS) && (k >= 2))) bad++;
      if ((idx < NS) && (paddr !== v.addr || pwrite !== v.wr ||
                         pwdata !== v.wdata || pstrb !== v.strb)) bad++;
    end
    if (psel !== 4'h0 || penable !== 1'b0) bad++;
    check({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
    check({tag, "_apb_seq"}, 32'(bad), 32'd0);
    check({tag, "_rdata"}, rsp_rdata, v.exp_rdata);
    check({tag, "_err"}, 32'(rsp_err), 32'(v.exp_err));
    if (lat == 0) begin
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end
    r0 = rsp_rdata; e0 = rsp_err; hbad = 0;
    for (int j = 0; j < v.hold; j++) begin
      req_valid = 1'b1; req_addr = 32'($urandom_range(0, 32'h3fff)); req_write = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== r0 || rsp_err !== e0 ||
          req_ready !== 1'b0 || psel !== 4'h0) hbad++;
    end
    req_valid = 1'b0;
    if (v.hold > 0) check({tag, "_hold"}, 32'(hbad), 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({tag, "_post_hs"}, {29'd0, rsp_valid, req_ready, |psel}, 32'b010);
  endtask

  initial begin
    for (int i = 0; i < NS; i++) begin
      prdata[i] = '0; slv_wait[i] = 0; slv_data[i] = '0; slv_err[i] = 1'b0;
    end
    //          addr          wr    wdata         strb  wait sdata         serr  hold  err   rdata         lat
    tbl[0] = '{32'h0000_1004, 1'b0, 32'h0,        4'h0, 0,   32'hCAFE0001, 1'b0, 0,    1'b0, 32'hCAFE0001, 3};
    tbl[1] = '{32'h0000_0010, 1'b1, 32'h12345678, 4'hF, 5,   32'hFFFFFFFF, 1'b0, 0,    1'b0, 32'h0,        8};
    tbl[2] = '{32'h0000_5000, 1'b0, 32'h0,        4'h0, 0,   32'h0,        1'b0, 0,    1'b1, 32'h0,        1};
    tbl[3] = '{32'h0000_2000, 1'b0, 32'h0,        4'h0, 255, 32'h11111111, 1'b0, 0,    1'b1, 32'h0,        11};
    tbl[4] = '{32'h0000_3008, 1'b0, 32'h0,        4'h0, 1,   32'hDEADBEEF, 1'b1, 0,    1'b1, 32'hDEADBEEF, 4};
    tbl[5] = '{32'h0000_2004, 1'b0, 32'h0,        4'h0, 8,   32'h0BADF00D, 1'b0, 0,    1'b0, 32'h0BADF00D, 11};
    tbl[6] = '{32'h0000_2008, 1'b0, 32'h0,        4'h0, 9,   32'h77777777, 1'b0, 0,    1'b1, 32'h0,        11};
    tbl[7] = '{32'h0000_1000, 1'b0, 32'h0,        4'h0, 0,   32'h55AA55AA, 1'b0, 10,   1'b0, 32'h55AA55AA, 3};
    tbl[8] = '{32'h0000_0FFC, 1'b1, 32'hA5A5A5A5, 4'h3, 2,   32'h12121212, 1'b1, 0,    1'b1, 32'h0,        5};
    tbl[9] = '{32'hFFFF_0000, 1'b1, 32'h9999AAAA, 4'hF, 0,   32'h0,        1'b0, 2,    1'b1, 32'h0,        1};

    // Reset values while rst_n is held low
    #12;
    check("rst_psel", 32'(psel), 32'd0);
    check("rst_penable", 32'(penable), 32'd0);
    check("rst_paddr", paddr, 32'd0);
    check("rst_pwdata", pwdata, 32'd0);
    check("rst_pwrite_pstrb", {27'd0, pwrite, pstrb}, 32'd0);
    check("rst_rsp", {31'd0, rsp_valid}, 32'd0);
    check("rst_rdata_err", rsp_rdata | 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_req_ready", 32'(req_ready), 32'd1);

    for (int t = 0; t < 10; t++) run_vec(tbl[t], $sformatf("tbl%0d", t));

    // Reset asserted during ACCESS of a transfer that would otherwise time out
    begin
      int rbad;
      slv_wait[1] = 255;
      @(negedge clk);
      req_valid = 1'b1; req_addr = 32'h0000_1010; req_write = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mid_access_penable", {31'd0, penable}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_drop", {29'd0, |psel, penable, rsp_valid}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      rbad = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || psel !== 4'h0) rbad++;
      end
      check("post_rst_quiet", 32'(rbad), 32'd0);
      run_vec(tbl[0], "post_rst_read");
    end

    // Randomized transfers against the model
    for (int t = 0; t < 40; t++) begin
      vec_t v;
      int   s;
      s = $urandom_range(0, 4);
      if (s == 4) v.addr = $urandom | 32'h0000_4000;
      else        v.addr = (32'(s) << RB) | 32'($urandom_range(0, 4095));
      v.wr    = 1'($urandom);
      v.wdata = $urandom;
      v.strb  = 4'($urandom);
      v.swait = $urandom_range(0, 10);
      v.sdata = $urandom;
      v.serr  = ($urandom_range(0, 3) == 0);
      v.hold  = $urandom_range(0, 3);
      v.exp_err = 1'b0; v.exp_rdata = '0; v.exp_lat = 0;
      v = model(v);
      run_vec(v, $sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Safety bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
